// File: rtl/mc_cpu_core.sv
// Multi-cycle MIPS-subset core sharing a single req/ready memory port between fetch and data access.
// Memory-port outputs decode registered state, so mem_req falls with run as soon as rst_n asserts.
module mc_cpu_core #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned CNT_W         = 32,
    parameter bit          TRAP_MISALIGN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ready,
    input  logic [31:0]      mem_rdata,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [31:0]      PC_out,
    output logic [31:0]      R31_out
);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL = 6'h03, OP_BEQ  = 6'h04,
                           OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D,
                           OP_LW    = 6'h23, OP_SW   = 6'h2B, OP_HALT = 6'h3F;
    localparam logic [5:0] FN_SLL = 6'h00, FN_JR = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22,
                           FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t      state;
    logic        run;
    logic [31:0] pc, npc, ir, a, b, imm, result;
    logic [4:0]  dst;
    logic [31:0] rf [32];

    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, shamt;
    logic        known, use_zext, misaligned, taken;
    logic [31:0] alu, ls_addr;

    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign shamt = ir[10:6];
    assign fn    = ir[5:0];

    always_comb begin
        known    = 1'b0;
        use_zext = (op == OP_ANDI) || (op == OP_ORI);
        case (op)
            OP_RTYPE: known = fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_JR};
            OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL: known = 1'b1;
            default:  known = 1'b0;
        endcase
    end

    always_comb begin
        alu = '0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD:  alu = a + b;
                    FN_SUB:  alu = a - b;
                    FN_AND:  alu = a & b;
                    FN_OR:   alu = a | b;
                    FN_SLT:  alu = {31'd0, $signed(a) < $signed(b)};
                    FN_SLL:  alu = b << shamt;
                    default: alu = '0;
                endcase
            end
            OP_ADDI: alu = a + imm;
            OP_ANDI: alu = a & imm;
            OP_ORI:  alu = a | imm;
            default: alu = '0;
        endcase
    end

    assign ls_addr    = a + imm;
    assign misaligned = ls_addr[1:0] != 2'b00;
    assign taken      = (a == b) ^ (op == OP_BNE);

    always_comb begin
        mem_req   = run && (state == S_FETCH || state == S_MEM);
        mem_we    = mem_req && (state == S_MEM) && (op == OP_SW);
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_req) mem_addr = (state == S_MEM) ? result : pc;
        if (mem_we)  mem_wdata = b;
    end

    assign PC_out  = pc;
    assign R31_out = rf[31];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            run     <= 1'b0;
            pc      <= RESET_PC;
            npc     <= '0;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            imm     <= '0;
            result  <= '0;
            dst     <= '0;
            retired <= '0;
            halted  <= 1'b0;
            illegal <= 1'b0;
            for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            run <= 1'b1;
            case (state)
                S_FETCH: begin
                    if (run && mem_ready) begin
                        ir    <= mem_rdata;
                        npc   <= pc + 32'd4;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a   <= rf[rs];
                    b   <= rf[rt];
                    imm <= use_zext ? {16'h0000, ir[15:0]} : {{16{ir[15]}}, ir[15:0]};
                    if (op == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else if (!known) begin
                        halted  <= 1'b1;
                        illegal <= 1'b1;
                        state   <= S_HALT;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (op)
                        OP_RTYPE: begin
                            if (fn == FN_JR) begin
                                pc      <= a;
                                retired <= retired + CNT_W'(1);
                                state   <= S_FETCH;
                            end else begin
                                result <= alu;
                                dst    <= rd;
                                state  <= S_WB;
                            end
                        end
                        OP_ADDI, OP_ANDI, OP_ORI: begin
                            result <= alu;
                            dst    <= rt;
                            state  <= S_WB;
                        end
                        OP_LW, OP_SW: begin
                            // With trapping enabled the masked address equals ls_addr whenever MEM is reached.
                            if (TRAP_MISALIGN && misaligned) begin
                                halted  <= 1'b1;
                                illegal <= 1'b1;
                                state   <= S_HALT;
                            end else begin
                                result <= {ls_addr[31:2], 2'b00};
                                state  <= S_MEM;
                            end
                        end
                        OP_BEQ, OP_BNE: begin
                            pc      <= taken ? npc + (imm << 2) : npc;
                            retired <= retired + CNT_W'(1);
                            state   <= S_FETCH;
                        end
                        OP_J, OP_JAL: begin
                            pc <= {npc[31:28], ir[25:0], 2'b00};
                            if (op == OP_JAL) rf[31] <= npc;
                            retired <= retired + CNT_W'(1);
                            state   <= S_FETCH;
                        end
                        default: state <= S_HALT;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (op == OP_SW) begin
                            pc      <= npc;
                            retired <= retired + CNT_W'(1);
                            state   <= S_FETCH;
                        end else begin
                            result <= mem_rdata;
                            dst    <= rt;
                            state  <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (dst != 5'd0) rf[dst] <= result;
                    pc      <= npc;
                    retired <= retired + CNT_W'(1);
                    state   <= S_FETCH;
                end
                default: state <= S_HALT;
            endcase
        end
    end

endmodule
